// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory port, decode handshake, redirect and fault status.
interface fetch_sequencer_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          fetch_en;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_word;
   logic          instr_valid;
   logic [31:0]   instr;
   logic [31:0]   instr_pc;
   logic          instr_ready;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          fault;
   logic [31:0]   fault_pc;
   logic [CW-1:0] occupancy;

   modport master (
      input  fetch_en, imem_word, instr_ready, redirect_valid, redirect_pc,
      output imem_addr, instr_valid, instr, instr_pc, fault, fault_pc, occupancy
   );

   modport slave (
      output fetch_en, imem_word, instr_ready, redirect_valid, redirect_pc,
      input  imem_addr, instr_valid, instr, instr_pc, fault, fault_pc, occupancy
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Drives the combinational instruction ROM, buffers {pc, word} pairs in a small FIFO
// and hands them to decode; stops on an unprogrammed-ROM read until redirected.
module fetch_sequencer #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BAD_WORD = 32'hFFFF_FFFF
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   q_word [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   pc;
   logic          fault;
   logic [31:0]   fault_pc;

   logic head_valid;
   logic deq;
   logic enq;
   logic word_bad;
   logic push;
   logic fault_hit;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head_valid = (count != '0);
   assign deq        = head_valid & bus.instr_ready;
   assign enq        = bus.fetch_en & ~fault & ~bus.redirect_valid
                       & ((count < CW'(DEPTH)) | deq);
   assign word_bad   = (bus.imem_word == BAD_WORD);
   assign push       = enq & ~word_bad;
   assign fault_hit  = enq & word_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         pc       <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else if (bus.redirect_valid) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         pc       <= {bus.redirect_pc[31:2], 2'b00};
         fault    <= 1'b0;
         fault_pc <= '0;
      end else begin
         if (deq) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push) begin
            q_word[wr_ptr] <= bus.imem_word;
            q_pc[wr_ptr]   <= pc;
            wr_ptr         <= ptr_inc(wr_ptr);
            pc             <= pc + 32'd4;
         end
         // PC stays on the faulting address so fault_pc and imem_addr agree.
         if (fault_hit) begin
            fault    <= 1'b1;
            fault_pc <= pc;
         end
         case ({push, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head_valid ? q_word[rd_ptr] : '0;
   assign bus.instr_pc    = head_valid ? q_pc[rd_ptr]   : '0;
   assign bus.fault       = fault;
   assign bus.fault_pc    = fault ? fault_pc : '0;
   assign bus.occupancy   = count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory for the MIPS core.
- Drives the fetch address and captures each returned word with its PC into a small prefetch queue.
- Hands instructions to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and flags fetches from unprogrammed ROM locations, which return 32'hFFFF_FFFF.

Parameters:
- DEPTH, 2: prefetch queue entries; legal range 1..8.
- RESET_PC, 32'h0000_0000: fetch address after reset; word-aligned.
- BAD_WORD, 32'hFFFF_FFFF: memory return value treated as a fetch fault.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = allowed to issue new fetches; 0 = hold PC, queue still drains.
- imem_addr  out  32  address to instruction memory; always equals the internal PC.
- imem_word  in  32  word returned combinationally by the memory for imem_addr in the same cycle.
- instr_valid  out  1  queue head is valid.
- instr  out  32  head instruction; 0 when instr_valid=0.
- instr_pc  out  32  address of the head instruction; 0 when instr_valid=0.
- instr_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- fault  out  1  sticky: a BAD_WORD was fetched and fetching has stopped.
- fault_pc  out  32  address that returned BAD_WORD; 0 when fault=0.
- occupancy  out  $clog2(DEPTH+1)  number of valid queue entries.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - PC=RESET_PC, queue empty, fault=0, fault_pc=0.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, occupancy=0, imem_addr=RESET_PC.
- Enqueue condition: fetch_en & !fault & !redirect_valid & (occupancy<DEPTH | deq), where deq = instr_valid & instr_ready.
  - A full queue with a simultaneous dequeue still enqueues.
- Normal enqueue (imem_word != BAD_WORD): push {imem_addr, imem_word}; PC <= PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- Fault enqueue (imem_word == BAD_WORD): nothing is pushed; fault<=1, fault_pc<=imem_addr, PC unchanged.
  - While fault=1 no fetch is issued.
  - Entries already in the queue still drain.
- Latency: a word fetched in cycle N is visible on instr/instr_valid in cycle N+1. Back-to-back throughput is 1 instruction per cycle with instr_ready held at 1.
- Dequeue: when instr_valid & instr_ready, pop the head at the edge. Queue order is strict FIFO.
- Redirect (redirect_valid=1 at an edge): queue flushed (occupancy<=0), PC<={redirect_pc[31:2],2'b00}, fault<=0, fault_pc<=0.
  - Redirect overrides any same-cycle enqueue or dequeue.
  - A head accepted in the same cycle is considered consumed by decode; the block takes no further action for it.
  - The first instruction from the new PC appears 2 cycles after the redirect edge: fetched in cycle N+1, valid in cycle N+2.
- fetch_en=0: PC and fault hold; dequeue proceeds normally.
- Internal state is a circular buffer with read/write pointers and a count.
  - Pointer wrap at DEPTH must work for non-power-of-2 DEPTH.
  - Empty: instr_valid=0, outputs zeroed.
  - Full: no enqueue unless a dequeue happens in the same cycle.
- Reset asserted mid-stream discards all queued entries and any fault, with no partial state retained.

Test Plan:
1. Memory model returns 32'h2400_0120 @0, 32'h2421_0120 @4, 32'h2442_0120 @8; release reset with instr_ready=1 -> instr_valid rises 1 cycle later; instr_pc sequence 0,4,8 on consecutive cycles with matching words.
2. instr_ready=0 for 5 cycles after reset -> occupancy saturates at 2, imem_addr holds 8; raising instr_ready delivers PCs 0,4,8 with no gap or duplicate.
3. Model returns BAD_WORD from address 0x84 upward, with 0x80 returning 32'h0800_0080 -> 0x80 is delivered, then fault=1 with fault_pc=0x84; instr_valid drops once the queue drains and imem_addr stays at 0x84.
4. While faulted, pulse redirect_valid with redirect_pc=0x13 -> fault=0, fault_pc=0, queue flushed, imem_addr=0x10 next cycle, first instr_pc=0x10 two cycles after the redirect edge.
5. Full queue with instr_valid & instr_ready & redirect_valid in the same cycle, redirect_pc=0x40 -> occupancy=0 next cycle, no stale PC is ever presented, next delivered instr_pc=0x40.
6. Assert reset for 1 cycle mid-stream with occupancy=2 -> next cycle instr_valid=0, occupancy=0, imem_addr=RESET_PC.
